wb_dcache_mem_bridge: RTL

- Downstream neighbour of the write-back data cache. Sits between the data-cache memory port and the narrower system data bus.
- Turns each cache-line request into a burst of bus beats: writes for evictions, reads for refills. Read beats are assembled into a full line.
- Returns a single-cycle ack to the cache controller and honours the cache's kill signal.

---
 rtl/wb_dcache_mem_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_dcache_mem_bridge.sv
// wb_dcache_mem_bridge
//   Bridges the write-back data cache memory port onto the narrower system
//   data bus. Each line request becomes a burst of BEATS bus beats: writes
//   for evictions, reads for refills (read beats are assembled into a line).
//   A single-cycle ack reports completion; a kill aborts the burst after the
//   in-flight beat and suppresses the ack.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   dcache_req_i         line transfer request (sampled only in IDLE)
//   dcache_wr_i          1 = write-back, 0 = refill
//   dcache_addr_i        line address (offset bits within the line ignored)
//   dcache_wdata_i       line to write back
//   dcache_kill_i        abort current transfer
//   mem2dcache_ack_o     one-cycle completion pulse
//   mem2dcache_rdata_o   assembled refill line
//   bus_valid_o/we_o/addr_o/wdata_o   beat request (all register-derived)
//   bus_ready_i          beat accepted; read data valid in the same cycle
//   bus_rdata_i          beat read data
module wb_dcache_mem_bridge #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dcache_req_i,
    input  logic                  dcache_wr_i,
    input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache_wdata_i,
    input  logic                  dcache_kill_i,
    output logic                  mem2dcache_ack_o,
    output logic [LINE_WIDTH-1:0] mem2dcache_rdata_o,
    output logic                  bus_valid_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [BUS_WIDTH-1:0]  bus_wdata_o,
    input  logic                  bus_ready_i,
    input  logic [BUS_WIDTH-1:0]  bus_rdata_i
);

    localparam int unsigned BEATS     = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned CNT_W     = $clog2(BEATS);
    localparam int unsigned BUS_BYTES = BUS_WIDTH / 8;
    localparam int unsigned BUS_OFF   = $clog2(BUS_BYTES);
    localparam int unsigned LINE_OFF  = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((64'd1 << LINE_OFF) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic                    abort;
    logic                    wr;
    logic [ADDR_WIDTH-1:0]   base;
    logic [LINE_WIDTH-1:0]   line;
    logic [LINE_WIDTH-1:0]   rdata;
    logic                    start;
    logic                    handshake;
    logic                    in_beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        start            = 1'b0;
        handshake        = 1'b0;
        in_beat          = (state == BEAT);
        mem2dcache_ack_o = (state == DONE);
        case (state)
            IDLE: begin
                if (dcache_req_i) begin
                    start      = 1'b1;
                    state_next = BEAT;
                end
            end
            BEAT: begin
                if (bus_ready_i) begin
                    handshake = 1'b1;
                    // A kill seen now or earlier makes this beat the last one.
                    if (abort || dcache_kill_i) begin
                        state_next = IDLE;
                    end else if (cnt == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs come straight from registers and are forced to zero outside
    // a burst, so they hold steady across backpressure.
    always_comb begin
        bus_valid_o = in_beat;
        bus_we_o    = in_beat & wr;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        if (in_beat) begin
            bus_addr_o  = base + (ADDR_WIDTH'(cnt) << BUS_OFF);
            bus_wdata_o = line[32'(cnt) * BUS_WIDTH +: BUS_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            abort <= 1'b0;
            wr    <= 1'b0;
            base  <= '0;
            line  <= '0;
            rdata <= '0;
        end else begin
            if (start) begin
                base  <= dcache_addr_i & ~LINE_MASK;
                line  <= dcache_wdata_i;
                wr    <= dcache_wr_i;
                cnt   <= '0;
                abort <= 1'b0;
            end
            if (in_beat && dcache_kill_i) begin
                abort <= 1'b1;
            end
            if (handshake) begin
                if (!wr) begin
                    rdata[32'(cnt) * BUS_WIDTH +: BUS_WIDTH] <= bus_rdata_i;
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign mem2dcache_rdata_o = rdata;

endmodule
